hamming74_decoder_pipe: RTL

Downstream stage of the Hamming(7,4) encoder. Accepts 7-bit codewords over a valid/ready handshake and computes the 3-bit syndrome. Corrects any single-bit error and emits the 4-bit data word through a 2-stage pipeline. Keeps a saturating count of corrected words for status readout.

---
 rtl/hamming74_decoder_pipe.sv | 118 +++++++++++
 1 files changed

// File: rtl/hamming74_decoder_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hamming74_decoder_pipe : 2-stage valid/ready Hamming(7,4) decoder with
// single-error correction and a saturating corrected-word counter.
// Revision 1.0
// ---------------------------------------------------------------------------
module hamming74_decoder_pipe #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [2:0]       out_syndrome,
  output logic             out_corrected,
  input  logic             err_clear,
  output logic [CNT_W-1:0] err_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [6:0]       s1_code_q, s1_code_d;
  logic             s2_valid_q, s2_valid_d;
  logic [3:0]       s2_data_q, s2_data_d;
  logic [2:0]       s2_syn_q, s2_syn_d;
  logic             s2_corr_q, s2_corr_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic             s2_adv;
  logic             s1_adv;
  logic [2:0]       s1_syn;
  logic [3:0]       s1_data_fix;
  logic             err_inc;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv && !rst;

  // Only syndromes 3,5,6,7 point at data bits; parity-bit errors leave data alone.
  always_comb begin
    s1_syn[0]   = s1_code_q[0] ^ s1_code_q[2] ^ s1_code_q[4] ^ s1_code_q[6];
    s1_syn[1]   = s1_code_q[1] ^ s1_code_q[2] ^ s1_code_q[5] ^ s1_code_q[6];
    s1_syn[2]   = s1_code_q[3] ^ s1_code_q[4] ^ s1_code_q[5] ^ s1_code_q[6];
    s1_data_fix = {s1_code_q[6] ^ (s1_syn == 3'd7),
                   s1_code_q[5] ^ (s1_syn == 3'd6),
                   s1_code_q[4] ^ (s1_syn == 3'd5),
                   s1_code_q[2] ^ (s1_syn == 3'd3)};
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_code_d = in_code;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_syn_d   = s2_syn_q;
    s2_corr_d  = s2_corr_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = s1_data_fix;
        s2_syn_d  = s1_syn;
        s2_corr_d = (s1_syn != 3'd0);
      end
    end
  end

  assign err_inc = s2_valid_q && out_ready && s2_corr_q;

  // A clear that coincides with a counted beat leaves that beat counted.
  always_comb begin
    err_count_d = err_count_q;
    if (err_clear) begin
      err_count_d = err_inc ? CNT_W'(1) : '0;
    end else if (err_inc && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_syn_q    <= '0;
      s2_corr_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_code_q   <= s1_code_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_syn_q    <= s2_syn_d;
      s2_corr_q   <= s2_corr_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_data      = s2_data_q;
  assign out_syndrome  = s2_syn_q;
  assign out_corrected = s2_corr_q;
  assign err_count     = err_count_q;

endmodule
`default_nettype wire
